// File: rtl/one_to_four_demux_deserializer.sv
// one_to_four_demux_deserializer: four-channel MSB-first serial-to-byte collector with a round-robin output port
module one_to_four_demux_deserializer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_bit,
  input  logic       s0,
  input  logic       s1,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_ch,
  output logic       out_valid,
  input  logic       out_ready
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t st, st_nx;
  logic [7:0] sr [4];
  logic [2:0] cnt [4];
  logic [3:0] full;
  logic [1:0] rr, ch, win;
  logic acc, any, load;
  assign ch = {s1, s0};
  assign in_ready = ~full[ch];
  assign acc = in_valid & in_ready;
  assign any = |full;
  assign out_valid = st == PRESENT;
  // descending scan so the nearest channel after rr wins
  always_comb begin
    win = rr;
    for (int k = 4; k >= 1; k--) if (full[rr + 2'(k)]) win = rr + 2'(k);
    load = any && (st == IDLE || out_ready);
    st_nx = st == IDLE ? (any ? PRESENT : IDLE) : (out_ready && !any ? IDLE : PRESENT);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      rr <= 2'd3;
      out_data <= 8'h00;
      out_ch <= 2'b00;
      full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        sr[i] <= 8'h00;
        cnt[i] <= 3'd0;
      end
    end else begin
      st <= st_nx;
      if (load) begin
        out_data <= sr[win];
        out_ch <= win;
        rr <= win;
      end
      for (int i = 0; i < 4; i++) begin
        if (acc && ch == 2'(i)) begin
          sr[i] <= {sr[i][6:0], in_bit};
          cnt[i] <= cnt[i] + 3'd1;
        end
        full[i] <= (full[i] && !(load && win == 2'(i))) || (acc && ch == 2'(i) && cnt[i] == 3'd7);
      end
    end
  end
endmodule

// File: tb/tb_one_to_four_demux_deserializer.sv
// tb_one_to_four_demux_deserializer: directed stimulus with a queued scoreboard checked by a handshake monitor
module tb_one_to_four_demux_deserializer;
  logic clk = 1'b0, reset_n, in_bit, s0, s1, in_valid, out_ready;
  logic in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  int checks = 0, errors = 0;
  logic [9:0] q [$];
  always #5 clk = ~clk;
  one_to_four_demux_deserializer dut (
    .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .s0(s0), .s1(s1), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_bit(input logic [1:0] c, input logic b);
    s1 = c[1]; s0 = c[0]; in_bit = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic send_word(input logic [1:0] c, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(c, w[i]);
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, q.size(), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bad;
    reset_n = 1'b0; in_bit = 1'b0; s0 = 1'b0; s1 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (reset_n && out_valid && out_ready) begin
          if (q.size() == 0) chk("unexpected_word", {22'd0, out_ch, out_data}, 32'h3ff);
          else chk("word", {22'd0, out_ch, out_data}, {22'd0, q.pop_front()});
        end
      end
    join_none
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    // ch2 word 0xB2, single-cycle valid one edge after the last accept
    out_ready = 1'b1;
    q.push_back({2'd2, 8'hB2});
    send_word(2'd2, 8'hB2);
    chk("b2_not_yet", out_valid, 0);
    @(posedge clk); #1;
    chk("b2_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("b2_one_cycle", out_valid, 0);
    // ch0 and ch1 complete on consecutive edges while stalled
    out_ready = 1'b0;
    for (int i = 7; i >= 1; i--) send_bit(2'd0, 8'h5A >> i);
    for (int i = 7; i >= 1; i--) send_bit(2'd1, 8'hC3 >> i);
    q.push_back({2'd0, 8'h5A});
    q.push_back({2'd1, 8'hC3});
    send_bit(2'd0, 1'b0);
    send_bit(2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {out_valid, out_ch, out_data}, {1'b1, 2'd0, 8'h5A});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_valid_ch1", {out_valid, out_ch, out_data}, {1'b1, 2'd1, 8'hC3});
    @(posedge clk); #1;
    chk("b2b_idle", out_valid, 0);
    // ch1 served last, then ch0 and ch2 wait: ch2 must come first
    out_ready = 1'b0;
    q.push_back({2'd1, 8'h11});
    q.push_back({2'd2, 8'h22});
    q.push_back({2'd0, 8'h80});
    send_word(2'd1, 8'h11);
    send_word(2'd0, 8'h80);
    send_word(2'd2, 8'h22);
    out_ready = 1'b1;
    drain("rr_drain");
    // ch3 full blocks its own input but not ch2
    out_ready = 1'b0;
    q.push_back({2'd0, 8'h0F});
    q.push_back({2'd3, 8'h3C});
    send_word(2'd0, 8'h0F);
    send_word(2'd3, 8'h3C);
    s1 = 1'b1; s0 = 1'b1; in_bit = 1'b1; in_valid = 1'b1;
    #1 chk("ch3_full_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("ch3_full_ready2", in_ready, 0);
    s0 = 1'b0;
    #1 chk("ch2_ready", in_ready, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("full_drain");
    // asynchronous reset mid-word discards the partial ch3 bits
    out_ready = 1'b0;
    q.push_back({2'd1, 8'hA5});
    send_word(2'd1, 8'hA5);
    for (int i = 0; i < 5; i++) send_bit(2'd3, i[0] ? 1'b0 : 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_data", out_data, 0);
    chk("async_ch", out_ch, 0);
    chk("async_ready", in_ready, 1);
    q.delete();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    q.push_back({2'd3, 8'hFF});
    send_word(2'd3, 8'hFF);
    drain("post_reset_drain");
    // idle inputs must not disturb anything
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_bit = i[0]; s0 = i[1]; s1 = i[2];
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);
    q.push_back({2'd0, 8'h96});
    send_word(2'd0, 8'h96);
    drain("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
